// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer (main entry + skid entry). Control fields are zeroed
//   on bubble/flush; datapath fields are optionally held to save toggling.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      run enable; low acts as a continuous flush
//   flush_i      squash both entries
//   in_valid_i   upstream offers an instruction
//   in_ready_o   stage can accept (flop output, skid entry empty next cycle)
//   in_ctrl_i    upstream control field
//   in_data_i    upstream data field
//   out_valid_o  main entry holds a valid instruction
//   out_ready_i  downstream accepts (low = stall)
//   out_ctrl_o   control field, forced to zero when out_valid_o is low
//   out_data_o   data field of the main entry
//   occupancy_o  number of entries held (0, 1, 2)

module pipe_stage_reg #(
    parameter int unsigned CTRL_W              = 8,
    parameter int unsigned DATA_W              = 128,
    parameter bit          CLEAR_DATA_ON_FLUSH = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    // State encoding equals the number of held entries, so occupancy_o is
    // a direct view of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic acc;
    logic xfer;
    logic squash;

    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = ready_q;
    assign out_ctrl_o  = main_ctrl_q & {CTRL_W{out_valid_o}};
    assign out_data_o  = main_data_q;
    assign occupancy_o = state_q;

    assign acc    = in_valid_i & ready_q;
    assign xfer   = out_valid_o & out_ready_i;
    assign squash = flush_i | ~start_i;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (squash) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (acc && xfer) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end else if (acc) begin
                        // Main is stalled: park the new entry behind it.
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    // ready_q is low here, so acc cannot occur.
                    if (xfer) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Registered ready: decided from next-state so out_ready_i never
        // reaches in_ready_o combinationally.
        ready_d = start_i & (state_d != FULL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            ready_q     <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst_i, start_i, flush_i, in_valid_i, out_ready_i;
    logic [7:0]   in_ctrl_i;
    logic [127:0] in_data_i;

    logic         in_ready_o, out_valid_o;
    logic [7:0]   out_ctrl_o;
    logic [127:0] out_data_o;
    logic [1:0]   occupancy_o;

    logic         c_in_ready_o, c_out_valid_o;
    logic [7:0]   c_out_ctrl_o;
    logic [127:0] c_out_data_o;
    logic [1:0]   c_occupancy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [135:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CLEAR_DATA_ON_FLUSH(1'b0)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
        .occupancy_o(occupancy_o)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_clr (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(c_in_ready_o),
        .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
        .out_valid_o(c_out_valid_o), .out_ready_i(out_ready_i),
        .out_ctrl_o(c_out_ctrl_o), .out_data_o(c_out_data_o),
        .occupancy_o(c_occupancy_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mkdata(input logic [7:0] c);
        return {16{c}};
    endfunction

    // Offer one instruction; the stage is expected to be ready for it.
    task automatic offer(input logic [7:0] c, input logic [127:0] d);
        in_valid_i = 1'b1;
        in_ctrl_i  = c;
        in_data_i  = d;
        check("offer_ready", {127'd0, in_ready_o}, 128'd1);
        exp_q.push_back({c, d});
    endtask

    // Monitor: every downstream transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (!out_valid_o) check("bubble_ctrl", {120'd0, out_ctrl_o}, 128'd0);
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_out: got ctrl %0h want no output", out_ctrl_o);
                end else begin
                    logic [135:0] e;
                    e = exp_q.pop_front();
                    check("out_ctrl", {120'd0, out_ctrl_o}, {120'd0, e[135:128]});
                    check("out_data", out_data_o, e[127:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b1; flush_i = 1'b0;
        in_valid_i = 1'b1; in_ctrl_i = 8'hFF; in_data_i = '1; out_ready_i = 1'b1;

        // 1. reset with valid input offered
        tick(); tick();
        check("rst_valid", {127'd0, out_valid_o}, 128'd0);
        check("rst_ctrl",  {120'd0, out_ctrl_o}, 128'd0);
        check("rst_occ",   {126'd0, occupancy_o}, 128'd0);
        check("rst_ready", {127'd0, in_ready_o}, 128'd0);
        check("rst_data",  out_data_o, 128'd0);
        rst_i = 1'b0; in_valid_i = 1'b0;
        tick();
        check("post_rst_ready", {127'd0, in_ready_o}, 128'd1);

        // 2. streaming 0x01..0x05, one cycle latency, occupancy 1
        for (int i = 1; i <= 5; i++) begin
            offer(8'(i), mkdata(8'(i)));
            tick();
            check("stream_ctrl", {120'd0, out_ctrl_o}, 128'(i));
            check("stream_occ",  {126'd0, occupancy_o}, 128'd1);
        end
        in_valid_i = 1'b0;
        tick();
        check("stream_drain_occ", {126'd0, occupancy_o}, 128'd0);

        // 3. stall fills the skid, release drains in order
        out_ready_i = 1'b0;
        offer(8'h11, mkdata(8'h11));
        tick();
        offer(8'h12, mkdata(8'h12));
        tick();
        in_valid_i = 1'b0;
        check("full_occ",   {126'd0, occupancy_o}, 128'd2);
        check("full_ready", {127'd0, in_ready_o}, 128'd0);
        check("full_ctrl",  {120'd0, out_ctrl_o}, 128'h11);
        tick();
        check("stall_ctrl", {120'd0, out_ctrl_o}, 128'h11);
        check("stall_data", out_data_o, mkdata(8'h11));
        check("stall_occ",  {126'd0, occupancy_o}, 128'd2);
        out_ready_i = 1'b1;
        tick();
        check("rel_occ",   {126'd0, occupancy_o}, 128'd1);
        check("rel_ctrl",  {120'd0, out_ctrl_o}, 128'h12);
        check("rel_ready", {127'd0, in_ready_o}, 128'd1);
        offer(8'h13, mkdata(8'h13));
        tick();
        in_valid_i = 1'b0;
        check("c_ctrl", {120'd0, out_ctrl_o}, 128'h13);
        tick();
        check("s3_occ", {126'd0, occupancy_o}, 128'd0);

        // 4. flush while full, concurrent offer is dropped
        out_ready_i = 1'b0;
        offer(8'h21, mkdata(8'h21));
        tick();
        offer(8'h22, mkdata(8'h22));
        tick();
        in_valid_i = 1'b1; in_ctrl_i = 8'h23; in_data_i = mkdata(8'h23);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        exp_q.delete();
        check("fl_valid", {127'd0, out_valid_o}, 128'd0);
        check("fl_ctrl",  {120'd0, out_ctrl_o}, 128'd0);
        check("fl_occ",   {126'd0, occupancy_o}, 128'd0);
        check("fl_ready", {127'd0, in_ready_o}, 128'd1);
        out_ready_i = 1'b1;
        tick(); tick();
        check("fl_no_c", {127'd0, out_valid_o}, 128'd0);

        // 5. start_i low mid-stream
        offer(8'h31, mkdata(8'h31));
        tick();
        offer(8'h32, mkdata(8'h32));
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1; in_ctrl_i = 8'h33; in_data_i = mkdata(8'h33);
        tick();
        check("st_occ",   {126'd0, occupancy_o}, 128'd0);
        check("st_valid", {127'd0, out_valid_o}, 128'd0);
        check("st_ready", {127'd0, in_ready_o}, 128'd0);
        tick();
        check("st_ready2", {127'd0, in_ready_o}, 128'd0);
        in_valid_i = 1'b0; start_i = 1'b1;
        tick();
        check("st_resume_ready", {127'd0, in_ready_o}, 128'd1);

        // 6. data behaviour on flush for both CLEAR_DATA_ON_FLUSH settings
        out_ready_i = 1'b0;
        offer(8'h41, 128'hDEAD);
        tick();
        in_valid_i = 1'b0;
        check("d_keep_pre",  out_data_o, 128'hDEAD);
        check("d_clr_pre",   c_out_data_o, 128'hDEAD);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        exp_q.delete();
        check("d_keep_post", out_data_o, 128'hDEAD);
        check("d_clr_post",  c_out_data_o, 128'd0);
        check("d_clr_ctrl",  {120'd0, c_out_ctrl_o}, 128'd0);
        check("d_clr_occ",   {126'd0, c_occupancy_o}, 128'd0);

        out_ready_i = 1'b1;
        tick(); tick();
        check("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
